// File: rtl/bicintp_linebuf_if.sv
// ----------------------------------------------------------------------------
// bicintp_linebuf_if -- pixel write / vertical tap read bundle for the
// bicubic interpolation line buffer.
//   master : pixel source + tap reader (drives pix_*, rd_enb/rd_addr/rd_sel)
//   slave  : line buffer (drives rd_vld, p0..p3, ready, lines_avail, ovf)
// ----------------------------------------------------------------------------
interface bicintp_linebuf_if #(
  parameter int unsigned DW = 16
);
  logic          pix_vsync;
  logic          pix_vld;
  logic [DW-1:0] pix_data;
  logic          rd_enb;
  logic [9:0]    rd_addr;
  logic          rd_sel;
  logic          rd_vld;
  logic [DW-1:0] p0;
  logic [DW-1:0] p1;
  logic [DW-1:0] p2;
  logic [DW-1:0] p3;
  logic          ready;
  logic [4:0]    lines_avail;
  logic          ovf;

  modport master (
    output pix_vsync, pix_vld, pix_data, rd_enb, rd_addr, rd_sel,
    input  rd_vld, p0, p1, p2, p3, ready, lines_avail, ovf
  );

  modport slave (
    input  pix_vsync, pix_vld, pix_data, rd_enb, rd_addr, rd_sel,
    output rd_vld, p0, p1, p2, p3, ready, lines_avail, ovf
  );
endinterface

// File: rtl/bicintp_linebuf.sv
// ----------------------------------------------------------------------------
// bicintp_linebuf -- circular line buffer feeding a 4-tap vertical window
// (p0 top .. p3 bottom) to a bicubic interpolator.
//   sys_clk / sys_rst : single clock, synchronous active-high reset
//   bus (slave)       : pix_vsync/pix_vld/pix_data line writes,
//                       rd_enb/rd_addr read (1-cycle latency), rd_sel window
//                       advance, ready/lines_avail/ovf status
// Optional feature: define BICINTP_EDGE_REP_EN to replicate the first and
// last line of each frame into two slots (edge padding of the window).
// ----------------------------------------------------------------------------
module bicintp_linebuf #(
  parameter int unsigned DW     = 16,
  parameter int unsigned LINE_W = 640,
  parameter int unsigned FRM_H  = 480,
  parameter int unsigned LINE_N = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  bicintp_linebuf_if.slave    bus
);

  localparam int unsigned SW = $clog2(LINE_N);
  localparam int unsigned AW = $clog2(LINE_N * LINE_W);

  logic [DW-1:0] r_mem [LINE_N*LINE_W];

  logic [9:0]    r_wr_col;
  logic [9:0]    r_vcnt;
  logic [SW-1:0] r_wr_slot;
  logic [SW-1:0] r_rd_base;
  logic [4:0]    r_lines_avail;
  logic          r_ready;
  logic          r_ovf;
  logic          r_drop;
  logic          r_rd_vld;
  logic [DW-1:0] r_tap [4];

  logic          w_wr_acc;
  logic [1:0]    w_line_cnt;
  logic [4:0]    w_free;
  logic          w_drop;
  logic          w_line_end;
  logic          w_sel_acc;
  logic [4:0]    w_avail_nxt;
  logic [AW-1:0] w_wr_addr;
  logic          w_rd_oob;
  logic [AW-1:0] w_rd_addr [4];

  // Slots consumed by the line being written
`ifdef BICINTP_EDGE_REP_EN
  logic [AW-1:0] w_wr_addr2;
  assign w_line_cnt = (r_vcnt == 10'd0 || r_vcnt == 10'(FRM_H - 1)) ? 2'd2 : 2'd1;
  assign w_wr_addr2 = AW'(SW'(r_wr_slot + SW'(1))) * AW'(LINE_W) + AW'(r_wr_col);
`else
  assign w_line_cnt = 2'd1;
`endif

  // One slot is always kept free so the write slot never aliases a tap slot
  assign w_free      = 5'(LINE_N - 1) - r_lines_avail;
  assign w_wr_acc    = bus.pix_vld & ~bus.pix_vsync & ~sys_rst;
  // Drop decision is taken at column 0 and held for the rest of the line
  assign w_drop      = (r_wr_col == 10'd0) ? (w_free < 5'(w_line_cnt)) : r_drop;
  assign w_line_end  = w_wr_acc && (r_wr_col == 10'(LINE_W - 1));
  assign w_sel_acc   = bus.rd_sel & r_ready;
  assign w_avail_nxt = r_lines_avail
                     + ((w_line_end && !w_drop) ? 5'(w_line_cnt) : 5'd0)
                     - (w_sel_acc ? 5'd1 : 5'd0);
  assign w_wr_addr   = AW'(r_wr_slot) * AW'(LINE_W) + AW'(r_wr_col);
  assign w_rd_oob    = {1'b0, bus.rd_addr} >= 11'(LINE_W);

  // Tap addresses: slots rd_base+0..3 at the requested column
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_rd_addr[k] = AW'(SW'(r_rd_base + SW'(k))) * AW'(LINE_W) + AW'(bus.rd_addr);
    end
  end

  // Line RAM write port (contents survive reset)
  always_ff @(posedge sys_clk) begin
    if (w_wr_acc && !w_drop) begin
      r_mem[w_wr_addr] <= bus.pix_data;
`ifdef BICINTP_EDGE_REP_EN
      if (w_line_cnt == 2'd2) r_mem[w_wr_addr2] <= bus.pix_data;
`endif
    end
  end

  // Tap read: registered, holds while rd_enb is low
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rd_vld <= 1'b0;
      for (int k = 0; k < 4; k++) r_tap[k] <= '0;
    end else begin
      r_rd_vld <= bus.rd_enb;
      if (bus.rd_enb) begin
        for (int k = 0; k < 4; k++) r_tap[k] <= w_rd_oob ? '0 : r_mem[w_rd_addr[k]];
      end
    end
  end

  // Write pointers, window base and occupancy
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_wr_col      <= '0;
      r_vcnt        <= '0;
      r_wr_slot     <= '0;
      r_rd_base     <= '0;
      r_lines_avail <= '0;
      r_ready       <= 1'b0;
      r_ovf         <= 1'b0;
      r_drop        <= 1'b0;
    end else if (bus.pix_vsync) begin
      r_wr_col      <= '0;
      r_vcnt        <= '0;
      r_wr_slot     <= '0;
      r_rd_base     <= '0;
      r_lines_avail <= '0;
      r_ready       <= 1'b0;
      r_ovf         <= 1'b0;
      r_drop        <= 1'b0;
    end else begin
      if (w_sel_acc) r_rd_base <= r_rd_base + SW'(1);
      r_lines_avail <= w_avail_nxt;
      r_ready       <= (w_avail_nxt >= 5'd4);
      if (w_wr_acc) begin
        if (r_wr_col == 10'd0) begin
          r_drop <= w_drop;
          if (w_drop) r_ovf <= 1'b1;
        end
        if (w_line_end) begin
          r_wr_col <= '0;
          r_vcnt   <= (r_vcnt == 10'(FRM_H - 1)) ? 10'd0 : r_vcnt + 10'd1;
          if (!w_drop) r_wr_slot <= r_wr_slot + SW'(w_line_cnt);
        end else begin
          r_wr_col <= r_wr_col + 10'd1;
        end
      end
    end
  end

  assign bus.rd_vld      = r_rd_vld;
  assign bus.p0          = r_tap[0];
  assign bus.p1          = r_tap[1];
  assign bus.p2          = r_tap[2];
  assign bus.p3          = r_tap[3];
  assign bus.ready       = r_ready;
  assign bus.lines_avail = r_lines_avail;
  assign bus.ovf         = r_ovf;

endmodule

// File: tb/tb_bicintp_linebuf.sv
// ----------------------------------------------------------------------------
// tb_bicintp_linebuf -- self-checking bench for bicintp_linebuf.
// Directed frame scenarios followed by randomized traffic, all checked every
// cycle against a line-queue reference model.
// ----------------------------------------------------------------------------
module tb_bicintp_linebuf;

  localparam int unsigned DW     = 16;
  localparam int unsigned LINE_W = 640;
  localparam int unsigned FRM_H  = 6;
  localparam int unsigned LINE_N = 8;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;

  bicintp_linebuf_if #(.DW(DW)) bus ();

  bicintp_linebuf #(
    .DW(DW), .LINE_W(LINE_W), .FRM_H(FRM_H), .LINE_N(LINE_N)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: queue of stored line bases (pixel = base + column)
  logic [DW-1:0] m_win [$];
  int            m_col  = 0;
  int            m_vcnt = 0;
  bit            m_ovf  = 0;
  bit            m_drop = 0;
  logic [DW-1:0] m_base = '0;
  bit            m_vld  = 0;
  logic [DW-1:0] m_tap [4];
  bit            m_known = 0;

  function automatic int line_slots(input int vcnt);
`ifdef BICINTP_EDGE_REP_EN
    return (vcnt == 0 || vcnt == FRM_H - 1) ? 2 : 1;
`else
    return (vcnt < 0) ? 2 : 1;
`endif
  endfunction

  task automatic model_step(input bit rst, input bit vs, input bit vld, input logic [DW-1:0] d,
                            input bit enb, input logic [9:0] addr, input bit sel);
    bit pop;
    int cnt;
    if (rst) begin
      m_win.delete();
      m_col = 0; m_vcnt = 0; m_ovf = 0; m_drop = 0; m_vld = 0;
      for (int k = 0; k < 4; k++) m_tap[k] = '0;
      m_known = 1;
      return;
    end
    m_vld = enb;
    if (enb) begin
      if (int'(addr) >= LINE_W) begin
        for (int k = 0; k < 4; k++) m_tap[k] = '0;
        m_known = 1;
      end else if (m_win.size() >= 4) begin
        for (int k = 0; k < 4; k++) m_tap[k] = DW'(m_win[k] + addr);
        m_known = 1;
      end else begin
        m_known = 0;
      end
    end
    if (vs) begin
      m_win.delete();
      m_col = 0; m_vcnt = 0; m_ovf = 0; m_drop = 0;
      return;
    end
    pop = sel && (m_win.size() >= 4);
    if (vld) begin
      cnt = line_slots(m_vcnt);
      if (m_col == 0) begin
        m_drop = (int'(LINE_N) - 1 - m_win.size()) < cnt;
        if (m_drop) m_ovf = 1;
        m_base = d;
      end
      if (m_col == LINE_W - 1) begin
        if (!m_drop) for (int i = 0; i < cnt; i++) m_win.push_back(m_base);
        m_col  = 0;
        m_vcnt = (m_vcnt + 1) % FRM_H;
      end else begin
        m_col++;
      end
    end
    if (pop) void'(m_win.pop_front());
  endtask

  // One clock: drive, advance model, sample 1 time unit after the edge
  task automatic step(input bit rst, input bit vs, input bit vld, input logic [DW-1:0] d,
                      input bit enb, input logic [9:0] addr, input bit sel);
    sys_rst       = rst;
    bus.pix_vsync = vs;
    bus.pix_vld   = vld;
    bus.pix_data  = d;
    bus.rd_enb    = enb;
    bus.rd_addr   = addr;
    bus.rd_sel    = sel;
    model_step(rst, vs, vld, d, enb, addr, sel);
    @(posedge sys_clk);
    #1;
    check_eq("rd_vld", 32'(bus.rd_vld), 32'(m_vld));
    check_eq("lines_avail", 32'(bus.lines_avail), 32'(m_win.size()));
    check_eq("ready", 32'(bus.ready), 32'(m_win.size() >= 4));
    check_eq("ovf", 32'(bus.ovf), 32'(m_ovf));
    if (m_known) begin
      check_eq("p0", 32'(bus.p0), 32'(m_tap[0]));
      check_eq("p1", 32'(bus.p1), 32'(m_tap[1]));
      check_eq("p2", 32'(bus.p2), 32'(m_tap[2]));
      check_eq("p3", 32'(bus.p3), 32'(m_tap[3]));
    end
  endtask

  task automatic idle();
    step(0, 0, 0, '0, 0, '0, 0);
  endtask

  task automatic vsync();
    step(0, 1, 0, '0, 0, '0, 0);
  endtask

  task automatic rd(input logic [9:0] addr);
    step(0, 0, 0, '0, 1, addr, 0);
  endtask

  task automatic rd_advance();
    step(0, 0, 0, '0, 0, '0, 1);
  endtask

  task automatic write_line(input logic [DW-1:0] base, input bit sel_last);
    for (int c = 0; c < int'(LINE_W); c++)
      step(0, 0, 1, DW'(base + c), 0, '0, sel_last && (c == int'(LINE_W) - 1));
  endtask

  initial begin
    bus.pix_vsync = 0; bus.pix_vld = 0; bus.pix_data = '0;
    bus.rd_enb = 0; bus.rd_addr = '0; bus.rd_sel = 0;

    // Reset state
    step(1, 0, 0, '0, 0, '0, 0);
    step(1, 0, 0, '0, 0, '0, 0);
    idle();

    // Four lines, pixel = line*1000 + col, read column 5 and column edges
    for (int l = 0; l < 4; l++) write_line(DW'(l * 1000), 0);
    rd(10'd5);
`ifndef BICINTP_EDGE_REP_EN
    check_eq("d_avail4", 32'(bus.lines_avail), 32'd4);
    check_eq("d_p0", 32'(bus.p0), 32'd5);
    check_eq("d_p1", 32'(bus.p1), 32'd1005);
    check_eq("d_p2", 32'(bus.p2), 32'd2005);
    check_eq("d_p3", 32'(bus.p3), 32'd3005);
`endif
    rd(10'(LINE_W - 1));
    rd(10'(LINE_W));
    idle();

    // Frame restart, three lines: window not ready, rd_sel ignored
    vsync();
    for (int l = 0; l < 3; l++) write_line(DW'(l * 1000), 0);
`ifdef BICINTP_EDGE_REP_EN
    rd(10'd0);
    check_eq("d_rep_p0", 32'(bus.p0), 32'd0);
    check_eq("d_rep_p1", 32'(bus.p1), 32'd0);
    check_eq("d_rep_p2", 32'(bus.p2), 32'd1000);
    check_eq("d_rep_p3", 32'(bus.p3), 32'd2000);
`else
    rd_advance();
    check_eq("d_sel_ign", 32'(bus.lines_avail), 32'd3);
`endif
    rd(10'd700);
    check_eq("d_oob_vld", 32'(bus.rd_vld), 32'd1);
    check_eq("d_oob_p0", 32'(bus.p0), 32'd0);

    // Line completion coincident with accepted rd_sel
    vsync();
    for (int l = 0; l < 5; l++) write_line(DW'(l * 1000), 0);
    rd(10'd9);
    write_line(DW'(5000), 1);
`ifndef BICINTP_EDGE_REP_EN
    check_eq("d_coinc_avail", 32'(bus.lines_avail), 32'd5);
`endif
    rd(10'd9);
`ifndef BICINTP_EDGE_REP_EN
    check_eq("d_shift_p0", 32'(bus.p0), 32'd1009);
`endif

    // Overflow: eight lines with no reads
    vsync();
    for (int l = 0; l < 8; l++) write_line(DW'(l * 1000 + 7), 0);
`ifndef BICINTP_EDGE_REP_EN
    check_eq("d_ovf", 32'(bus.ovf), 32'd1);
    check_eq("d_ovf_avail", 32'(bus.lines_avail), 32'd7);
`endif
    rd(10'd3);
    vsync();
    check_eq("d_vs_ovf", 32'(bus.ovf), 32'd0);
    check_eq("d_vs_avail", 32'(bus.lines_avail), 32'd0);

    // Reset mid-line, then restart from column 0 / slot 0
    write_line(DW'(100), 0);
    write_line(DW'(1100), 0);
    for (int c = 0; c < 300; c++) step(0, 0, 1, DW'(2100 + c), 0, '0, 0);
    step(1, 0, 1, DW'(2400), 0, '0, 0);
    check_eq("d_rst_avail", 32'(bus.lines_avail), 32'd0);
    check_eq("d_rst_ready", 32'(bus.ready), 32'd0);
    for (int l = 0; l < 4; l++) write_line(DW'(40000 + l * 1000), 0);
    rd(10'd7);
`ifndef BICINTP_EDGE_REP_EN
    check_eq("d_rst_p0", 32'(bus.p0), 32'd40007);
`endif

    // Randomized traffic
    begin
      logic [DW-1:0] rbase;
      rbase = DW'($urandom);
      for (int n = 0; n < 10000; n++) begin
        bit            r_rst, r_vs, r_vld, r_enb, r_sel;
        logic [9:0]    r_addr;
        logic [DW-1:0] r_d;
        r_rst  = ($urandom_range(0, 1999) == 0);
        r_vs   = ($urandom_range(0, 1499) == 0);
        r_vld  = ($urandom_range(0, 9) < 8);
        r_enb  = ($urandom_range(0, 3) == 0);
        r_sel  = ($urandom_range(0, 299) == 0);
        r_addr = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(LINE_W - 2, 1023))
                                             : 10'($urandom_range(0, LINE_W - 1));
        if (m_col == 0) rbase = DW'($urandom);
        r_d = DW'(rbase + m_col);
        step(r_rst, r_vs, r_vld, r_d, r_enb, r_addr, r_sel);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bicintp_linebuf.md
BICINTP_LINEBUF -- requirements
Module: bicintp_linebuf

Interface
REQ-001 SHALL have parameter DW, default 16, meaning pixel width in bits.
REQ-002 SHALL have parameter LINE_W, default 640, meaning pixels per line, legal range 4..1024.
REQ-003 SHALL have parameter FRM_H, default 480, meaning lines per frame, legal range 4..1024.
REQ-004 SHALL have parameter LINE_N, default 8, meaning line slots; legal values 8 or 16 only (power of 2).
REQ-005 SHALL have port sys_clk, input, 1, the single clock for all logic.
REQ-006 SHALL have port sys_rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports pix_vsync, input, 1 (frame-start flush); pix_vld, input, 1 (pixel write strobe); pix_data, input, DW (pixel).
REQ-008 SHALL have ports rd_enb, input, 1 (tap read strobe); rd_addr, input, 10 (column); rd_sel, input, 1 (1-cycle pulse, advance window one line).
REQ-009 SHALL have ports rd_vld, output, 1; p0, p1, p2, p3, outputs, DW each (vertical taps, top to bottom).
REQ-010 SHALL have ports ready, output, 1; lines_avail, output, 5; ovf, output, 1 (sticky line drop).

Function
REQ-011 Write column wr_col SHALL count 0..LINE_W-1 on pix_vld and wrap to 0; each wrap completes one line and increments frame line counter vcnt, which wraps FRM_H-1 -> 0.
REQ-012 Line writes SHALL go to slot wr_slot; at line completion wr_slot advances mod LINE_N by the slot count of that line (1, or 2 when replicated per REQ-024).
REQ-013 lines_avail SHALL equal lines held from rd_base onward; it increments on line completion by that line's slot count, decrements by 1 on an accepted rd_sel; simultaneous events apply both in one cycle.
REQ-014 ready SHALL be 1 exactly when lines_avail >= 4.
REQ-015 rd_sel SHALL be accepted only when ready=1; an accepted rd_sel advances rd_base by 1 mod LINE_N from the next cycle; rd_sel with ready=0 is ignored.
REQ-016 rd_enb in cycle t SHALL give rd_vld=1 in t+1 with p0..p3 = slot (rd_base+0..3) mod LINE_N at column rd_addr, using rd_base of cycle t.
REQ-017 rd_addr >= LINE_W SHALL return p0..p3 = 0 with rd_vld=1.
REQ-018 p0..p3 SHALL hold their last value while rd_enb=0.
REQ-019 At column 0 of a line, if free slots (LINE_N-1-lines_avail) are fewer than the line's slot count, the whole line SHALL be dropped (no RAM write, no lines_avail change, vcnt still advances) and ovf set.
REQ-020 pix_vsync=1 SHALL in the next cycle clear wr_col, vcnt, wr_slot, rd_base, lines_avail and ovf; a pix_vld in the same cycle is dropped.
REQ-021 Storage SHALL be a single-clock RAM of LINE_N*LINE_W words of DW bits; write and read of different slots in one cycle both succeed.

Reset
REQ-022 sys_rst=1 at a sys_clk edge SHALL clear all counters and pointers; rd_vld, ready, ovf, lines_avail, p0..p3 read 0 the next cycle; RAM contents are not cleared.
REQ-023 Reset asserted mid-line SHALL discard the partial line; writes resume at column 0, vcnt 0.

Configuration
REQ-024 With macro BICINTP_EDGE_REP_EN defined, lines with vcnt=0 and vcnt=FRM_H-1 SHALL each be written into two consecutive slots (slot count 2), so the first window after frame start is rows 0,0,1,2 and the last is FRM_H-3..FRM_H-1,FRM_H-1.
REQ-025 Without BICINTP_EDGE_REP_EN, every line SHALL have slot count 1 and no replication logic is present.

Verification
REQ-026 Reset, write 4 lines LINE_W=640 with pixel = line*1000+col, no macro -> ready=1 after 4th line end, lines_avail=4; rd_enb addr 5 -> next cycle p0..p3 = 5,1005,2005,3005.
REQ-027 Macro defined, vsync then 3 lines -> lines_avail=4, ready=1; read addr 0 -> p0..p3 = 0,0,1000,2000.
REQ-028 Line completion coincident with accepted rd_sel at lines_avail=5 -> lines_avail stays 5; next read shows taps shifted down one line.
REQ-029 LINE_N=8, no reads, write 8 lines -> lines 0..6 stored, line 7 dropped, ovf=1, lines_avail=7; pix_vsync -> ovf=0, lines_avail=0.
REQ-030 rd_sel with lines_avail=3 -> ignored, lines_avail=3; rd_addr=700 -> p0..p3=0, rd_vld=1.
REQ-031 sys_rst asserted at column 300 of line 2 -> next cycle lines_avail=0, ready=0; next line written from column 0 into slot 0.
